// File: rtl/vc_ram_stream_reader_if.sv
// rtl/vc_ram_stream_reader_if.sv - command and output-stream handshake bundle for the RAM stream reader
interface vc_ram_stream_reader_if #(
    parameter int DATA_SZ = 32,
    parameter int ADDR_SZ = 4,
    parameter int CNT_SZ  = 5
);
    logic               cmd_val;
    logic               cmd_rdy;
    logic [ADDR_SZ-1:0] cmd_addr;
    logic [CNT_SZ-1:0]  cmd_len;
    logic               out_val;
    logic               out_rdy;
    logic [DATA_SZ-1:0] out_data;
    logic               out_last;

    modport master (
        output cmd_val, cmd_addr, cmd_len, out_rdy,
        input  cmd_rdy, out_val, out_data, out_last
    );

    modport slave (
        input  cmd_val, cmd_addr, cmd_len, out_rdy,
        output cmd_rdy, out_val, out_data, out_last
    );
endinterface

// File: rtl/vc_ram_stream_reader.sv
// rtl/vc_ram_stream_reader.sv - walks a combinational RAM read port and streams a burst through one output register
module vc_ram_stream_reader #(
    parameter int DATA_SZ = 32,
    parameter int ENTRIES = 16,
    parameter int ADDR_SZ = 4,
    parameter int CNT_SZ  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vc_ram_stream_reader_if.slave bus,
    output logic [ADDR_SZ-1:0]   raddr,
    input  logic [DATA_SZ-1:0]   rdata,
    output logic                 busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    localparam logic [ADDR_SZ-1:0] LAST_IDX  = ADDR_SZ'(ENTRIES - 1);
    localparam logic [ADDR_SZ:0]   ENTRIES_W = (ADDR_SZ + 1)'(ENTRIES);

    state_e             state_q, state_d;
    logic [ADDR_SZ-1:0] ptr_q, ptr_d;
    logic [CNT_SZ-1:0]  rem_q, rem_d;
    logic               out_val_q, out_val_d;
    logic               out_last_q, out_last_d;
    logic [DATA_SZ-1:0] out_data_q, out_data_d;
    logic               cmd_fire;
    logic               load;

    assign cmd_fire = bus.cmd_val && (state_q == IDLE);
    // The output register is free when empty or being drained this same edge.
    assign load     = (state_q == BUSY) && (!out_val_q || bus.out_rdy);

    assign bus.cmd_rdy  = (state_q == IDLE);
    assign bus.out_val  = out_val_q;
    assign bus.out_data = out_data_q;
    assign bus.out_last = out_last_q;
    assign raddr        = ptr_q;
    assign busy         = (state_q == BUSY) || out_val_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        out_val_d  = out_val_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;

        if (cmd_fire && (bus.cmd_len != '0)) begin
            ptr_d   = bus.cmd_addr;
            rem_d   = bus.cmd_len;
            state_d = BUSY;
        end

        if (load) begin
            out_data_d = rdata;
            out_val_d  = 1'b1;
            out_last_d = (rem_q == CNT_SZ'(1));
            ptr_d      = (ptr_q == LAST_IDX) ? '0 : ptr_q + ADDR_SZ'(1);
            rem_d      = rem_q - CNT_SZ'(1);
            if (rem_q == CNT_SZ'(1)) begin
                state_d = IDLE;
            end
        end else if (out_val_q && bus.out_rdy) begin
            out_val_d  = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            out_val_q  <= out_val_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && cmd_fire && ({1'b0, bus.cmd_addr} >= ENTRIES_W)) begin
            $display("RTL-ERROR: vc_ram_stream_reader cmd_addr %0d >= ENTRIES %0d", bus.cmd_addr, ENTRIES);
        end
        if ((1 << ADDR_SZ) < ENTRIES) begin
            $display("RTL-ERROR: vc_ram_stream_reader ADDR_SZ %0d too small for ENTRIES %0d", ADDR_SZ, ENTRIES);
        end
    end
`endif
endmodule

// File: tb/tb_vc_ram_stream_reader.sv
// tb/tb_vc_ram_stream_reader.sv - randomized bench with a queue-based burst model for vc_ram_stream_reader
module tb_vc_ram_stream_reader;
    localparam int DATA_SZ = 32;
    localparam int ENTRIES = 16;
    localparam int ADDR_SZ = 4;
    localparam int CNT_SZ  = 5;

    typedef struct {
        logic [DATA_SZ-1:0] data;
        logic               last;
    } beat_t;

    logic               clk;
    logic               reset_n;
    logic [ADDR_SZ-1:0] raddr;
    logic [DATA_SZ-1:0] rdata;
    logic               busy;
    logic [DATA_SZ-1:0] mem [ENTRIES];

    int    n_checks;
    int    n_errors;
    int    fire_cnt;
    logic  rdy_rand;
    beat_t exp_q[$];
    beat_t log_q[$];

    vc_ram_stream_reader_if #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .CNT_SZ(CNT_SZ)) bus ();

    vc_ram_stream_reader #(
        .DATA_SZ(DATA_SZ), .ENTRIES(ENTRIES), .ADDR_SZ(ADDR_SZ), .CNT_SZ(CNT_SZ)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .raddr  (raddr),
        .rdata  (rdata),
        .busy   (busy)
    );

    assign rdata = mem[raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted command expands into its full list of beats;
    // the DUT must present exactly that list in order, one entry per output fire.
    logic               prev_stall;
    logic               prev_free;
    logic [DATA_SZ-1:0] prev_data;
    logic               prev_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_free  = 1'b0;
        end else begin
            int unloaded;
            unloaded = exp_q.size() - (bus.out_val ? 1 : 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("cmd_rdy", bus.cmd_rdy, unloaded == 0);
            if (prev_stall) begin
                chk("stall_val", bus.out_val, 1'b1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            if (prev_free) chk("no_bubble", bus.out_val, 1'b1);
            if (bus.out_val) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("beat_data", bus.out_data, exp_q[0].data);
                    chk("beat_last", bus.out_last, exp_q[0].last);
                end
            end
            prev_stall = bus.out_val && !bus.out_rdy;
            prev_free  = (unloaded > 0) && (!bus.out_val || bus.out_rdy);
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.out_val && bus.out_rdy && exp_q.size() != 0) begin
                beat_t b;
                b.data = bus.out_data;
                b.last = bus.out_last;
                log_q.push_back(b);
                void'(exp_q.pop_front());
                fire_cnt++;
            end
            if (bus.cmd_val && bus.cmd_rdy) begin
                for (int i = 0; i < int'(bus.cmd_len); i++) begin
                    beat_t e;
                    e.data = mem[(int'(bus.cmd_addr) + i) % ENTRIES];
                    e.last = (i == int'(bus.cmd_len) - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        bus.out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic init_mem();
        for (int i = 0; i < ENTRIES; i++) mem[i] = 32'(i) * 32'h11;
    endtask

    // Starts and returns one time unit after a rising edge; returns just after the accept edge.
    task automatic send_cmd(input logic [ADDR_SZ-1:0] a, input logic [CNT_SZ-1:0] l);
        logic fired;
        fired = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_val  = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_len  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            fired = bus.cmd_rdy;
            @(posedge clk);
            #1;
            if (fired) break;
        end
        bus.cmd_val = 1'b0;
        if (!fired) chk("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_SZ-1:0] exp_d[5];
        logic [ADDR_SZ-1:0] exp_a[4];
        int                 base;
        n_checks     = 0;
        n_errors     = 0;
        fire_cnt     = 0;
        rdy_rand     = 1'b0;
        bus.cmd_val  = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len  = '0;
        init_mem();
        reset_n = 1'b1;

        // Asynchronous reset visible before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_val", bus.out_val, 1'b0);
        chk("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
        chk("rst_raddr", raddr, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_last", bus.out_last, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Simple burst with latency check.
        send_cmd(4'd3, 5'd4);
        @(negedge clk);
        chk("lat_out_val", bus.out_val, 1'b0);
        exp_d[0] = 32'h33; exp_d[1] = 32'h44; exp_d[2] = 32'h55; exp_d[3] = 32'h66;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2_val", bus.out_val, 1'b1);
            chk("b2_data", bus.out_data, exp_d[k]);
            chk("b2_last", bus.out_last, k == 3);
        end
        @(negedge clk);
        chk("b2_done", bus.out_val, 1'b0);
        wait_idle();

        // Pointer wrap.
        exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
        exp_d[0] = 32'hEE; exp_d[1] = 32'hFF; exp_d[2] = 32'h00; exp_d[3] = 32'h11;
        send_cmd(4'd14, 5'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) chk("wrap_raddr", raddr, exp_a[k]);
            if (k >= 1) chk("wrap_data", bus.out_data, exp_d[k-1]);
        end
        wait_idle();

        // Zero-length command.
        send_cmd(4'd7, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("len0_val", bus.out_val, 1'b0);
            chk("len0_rdy", bus.cmd_rdy, 1'b1);
        end

        // Back-to-back commands.
        log_q.delete();
        send_cmd(4'd0, 5'd2);
        send_cmd(4'd8, 5'd2);
        wait_idle();
        chk("b2b_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("b2b_d0", log_q[0].data, 32'h00); chk("b2b_l0", log_q[0].last, 1'b0);
            chk("b2b_d1", log_q[1].data, 32'h11); chk("b2b_l1", log_q[1].last, 1'b1);
            chk("b2b_d2", log_q[2].data, 32'h88); chk("b2b_l2", log_q[2].last, 1'b0);
            chk("b2b_d3", log_q[3].data, 32'h99); chk("b2b_l3", log_q[3].last, 1'b1);
        end

        // Reset mid-burst.
        log_q.delete();
        send_cmd(4'd0, 5'd8);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (log_q.size() >= 2) break;
        end
        chk("mid_beats", log_q.size(), 2);
        #1 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_val", bus.out_val, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rdy", bus.cmd_rdy, 1'b1);
        chk("mid_rst_raddr", raddr, 4'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", bus.cmd_rdy, 1'b1);
        log_q.delete();
        send_cmd(4'd5, 5'd1);
        wait_idle();
        chk("post_rst_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("post_rst_data", log_q[0].data, 32'h55);
            chk("post_rst_last", log_q[0].last, 1'b1);
        end

        // Long burst under random backpressure.
        rdy_rand = 1'b1;
        base = fire_cnt;
        send_cmd(4'($urandom_range(0, ENTRIES - 1)), 5'd20);
        wait_idle();
        chk("bp_beats", fire_cnt - base, 20);

        // Randomized command stream.
        for (int n = 0; n < 60; n++) begin
            logic [CNT_SZ-1:0] len;
            len = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            send_cmd(4'($urandom_range(0, ENTRIES - 1)), len);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                for (int i = 0; i < ENTRIES; i++) mem[i] = $urandom;
            end
        end
        wait_idle();
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
